// File: rtl/ysyx_23060077_wbu_if.sv
// Result/writeback bus of the writeback unit: EXU and LSU result channels
// plus the registered regfile write port.
interface ysyx_23060077_wbu_if #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  exu_valid;
    logic                  exu_ready;
    logic [REG_WIDTH-1:0]  exu_rd_addr;
    logic [DATA_WIDTH-1:0] exu_rd_data;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_WIDTH-1:0]  lsu_rd_addr;
    logic [DATA_WIDTH-1:0] lsu_rd_data;

    logic                  rd_en;
    logic [REG_WIDTH-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    // Producer side: EXU/LSU results in, regfile write observed.
    modport master (
        output exu_valid, exu_rd_addr, exu_rd_data,
        output lsu_valid, lsu_rd_addr, lsu_rd_data,
        input  exu_ready, lsu_ready,
        input  rd_en, rd_addr, rd_data
    );

    // Writeback unit side.
    modport slave (
        input  exu_valid, exu_rd_addr, exu_rd_data,
        input  lsu_valid, lsu_rd_addr, lsu_rd_data,
        output exu_ready, lsu_ready,
        output rd_en, rd_addr, rd_data
    );
endinterface

// File: rtl/ysyx_23060077_wbu.sv
// Writeback unit: arbitrates EXU/LSU results into one registered GPR write per
// cycle, tracks per-GPR pending writes and provides hazard/forwarding hints.
module ysyx_23060077_wbu #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 2 ** REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic                 issue_rd_en,
    input  logic [REG_WIDTH-1:0] issue_rd_addr,
    input  logic [REG_WIDTH-1:0] rs1_addr,
    input  logic [REG_WIDTH-1:0] rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rd_busy,
    output logic                 rs1_fwd,
    output logic                 rs2_fwd,
    ysyx_23060077_wbu_if.slave   wb,
    output logic [31:0]          wb_count,
    output logic                 sb_err
);
    logic                  fire_lsu;
    logic                  fire_exu;
    logic                  fire;
    logic [REG_WIDTH-1:0]  fire_addr;
    logic [DATA_WIDTH-1:0] fire_data;
    logic                  fire_nz;
    logic                  issue_set;
    logic [REG_COUNT-1:0]  busy;
    logic [REG_COUNT-1:0]  busy_nxt;

    // LSU has fixed priority; EXU is stalled while a load result is valid.
    assign wb.lsu_ready = 1'b1;
    assign wb.exu_ready = !wb.lsu_valid;

    assign fire_lsu  = wb.lsu_valid;
    assign fire_exu  = wb.exu_valid && !wb.lsu_valid;
    assign fire      = fire_lsu || fire_exu;
    assign fire_addr = fire_lsu ? wb.lsu_rd_addr : wb.exu_rd_addr;
    assign fire_data = fire_lsu ? wb.lsu_rd_data : wb.exu_rd_data;
    assign fire_nz   = fire && (fire_addr != '0);
    assign issue_set = issue_valid && issue_rd_en && (issue_rd_addr != '0);

    // Clear for the committing write first, so a same-edge issue set wins.
    always_comb begin
        busy_nxt = busy;
        if (fire_nz)
            busy_nxt[fire_addr] = 1'b0;
        if (issue_set)
            busy_nxt[issue_rd_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb.rd_en   <= 1'b0;
            wb.rd_addr <= '0;
            wb.rd_data <= '0;
            wb_count   <= '0;
            sb_err     <= 1'b0;
            busy       <= '0;
        end else begin
            wb.rd_en <= fire_nz;
            if (fire) begin
                wb.rd_addr <= fire_addr;
                wb.rd_data <= fire_data;
                wb_count   <= wb_count + 32'd1;
            end
            if (fire_nz && !busy[fire_addr])
                sb_err <= 1'b1;
            busy <= busy_nxt;
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
    assign rd_busy  = busy[issue_rd_addr];
    assign rs1_fwd  = wb.rd_en && (rs1_addr == wb.rd_addr);
    assign rs2_fwd  = wb.rd_en && (rs2_addr == wb.rd_addr);
endmodule

// File: tb/tb_ysyx_23060077_wbu.sv
// Directed self-checking bench for the writeback unit.
module tb_ysyx_23060077_wbu;
    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_rd_en;
    logic [4:0]  issue_rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic [31:0] wb_count;
    logic        sb_err;
    int          n_checks;
    int          n_errors;

    ysyx_23060077_wbu_if #(.REG_WIDTH(5), .DATA_WIDTH(32)) wb ();

    ysyx_23060077_wbu #(.REG_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rd_en   (issue_rd_en),
        .issue_rd_addr (issue_rd_addr),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rd_busy       (rd_busy),
        .rs1_fwd       (rs1_fwd),
        .rs2_fwd       (rs2_fwd),
        .wb            (wb.slave),
        .wb_count      (wb_count),
        .sb_err        (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_rd_en    = 1'b0;
        issue_rd_addr  = '0;
        wb.exu_valid   = 1'b0;
        wb.exu_rd_addr = '0;
        wb.exu_rd_data = '0;
        wb.lsu_valid   = 1'b0;
        wb.lsu_rd_addr = '0;
        wb.lsu_rd_data = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid   = 1'b1;
        issue_rd_en   = 1'b1;
        issue_rd_addr = rd;
        tick();
        issue_valid   = 1'b0;
        issue_rd_en   = 1'b0;
        issue_rd_addr = '0;
    endtask

    task automatic check_all_idle(input string tag);
        int unsigned nbusy;
        nbusy = 0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            #1;
            if (rs1_busy) nbusy++;
        end
        check(tag, nbusy, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        idle();

        // 1: reset held with random activity
        for (int i = 0; i < 6; i++) begin
            issue_valid    = 1'($urandom);
            issue_rd_en    = 1'($urandom);
            issue_rd_addr  = 5'($urandom);
            wb.exu_valid   = 1'($urandom);
            wb.exu_rd_addr = 5'($urandom);
            wb.exu_rd_data = $urandom;
            wb.lsu_valid   = 1'($urandom);
            wb.lsu_rd_addr = 5'($urandom);
            wb.lsu_rd_data = $urandom;
            tick();
        end
        check("rst_rd_en", 32'(wb.rd_en), 0);
        check("rst_rd_addr", 32'(wb.rd_addr), 0);
        check("rst_rd_data", wb.rd_data, 0);
        check("rst_wb_count", wb_count, 0);
        check("rst_sb_err", 32'(sb_err), 0);
        check_all_idle("rst_busy_count");
        idle();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_rd_en", 32'(wb.rd_en), 0);

        // 2: issue x5, EXU writes it back
        issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd_addr = 5'd5;
        #1;
        check("t2_rd_busy_same_cycle", 32'(rd_busy), 0);
        tick();
        issue_valid = 1'b0; issue_rd_en = 1'b0; issue_rd_addr = '0;
        rs1_addr = 5'd5;
        #1;
        check("t2_busy5_set", 32'(rs1_busy), 1);
        wb.exu_valid = 1'b1; wb.exu_rd_addr = 5'd5; wb.exu_rd_data = 32'hDEADBEEF;
        #1;
        check("t2_exu_ready", 32'(wb.exu_ready), 1);
        tick();
        wb.exu_valid = 1'b0;
        #1;
        check("t2_rd_en", 32'(wb.rd_en), 1);
        check("t2_rd_addr", 32'(wb.rd_addr), 5);
        check("t2_rd_data", wb.rd_data, 32'hDEADBEEF);
        check("t2_rs1_fwd", 32'(rs1_fwd), 1);
        check("t2_busy5_clr", 32'(rs1_busy), 0);
        check("t2_wb_count", wb_count, 1);
        tick();
        check("t2_rd_en_drop", 32'(wb.rd_en), 0);
        check("t2_rd_addr_hold", 32'(wb.rd_addr), 5);
        check("t2_rd_data_hold", wb.rd_data, 32'hDEADBEEF);
        check("t2_rs1_fwd_drop", 32'(rs1_fwd), 0);

        // 3: LSU wins over EXU
        issue(5'd3);
        issue(5'd7);
        rs1_addr = 5'd3; rs2_addr = 5'd7;
        #1;
        check("t3_busy3", 32'(rs1_busy), 1);
        check("t3_busy7", 32'(rs2_busy), 1);
        wb.exu_valid = 1'b1; wb.exu_rd_addr = 5'd3; wb.exu_rd_data = 32'h3333_0003;
        wb.lsu_valid = 1'b1; wb.lsu_rd_addr = 5'd7; wb.lsu_rd_data = 32'h7777_0007;
        #1;
        check("t3_exu_ready_blocked", 32'(wb.exu_ready), 0);
        check("t3_lsu_ready", 32'(wb.lsu_ready), 1);
        tick();
        wb.lsu_valid = 1'b0;
        #1;
        check("t3_first_addr", 32'(wb.rd_addr), 7);
        check("t3_first_data", wb.rd_data, 32'h7777_0007);
        check("t3_first_en", 32'(wb.rd_en), 1);
        check("t3_rs2_fwd", 32'(rs2_fwd), 1);
        check("t3_busy3_still", 32'(rs1_busy), 1);
        check("t3_exu_ready_now", 32'(wb.exu_ready), 1);
        tick();
        wb.exu_valid = 1'b0;
        #1;
        check("t3_second_addr", 32'(wb.rd_addr), 3);
        check("t3_second_data", wb.rd_data, 32'h3333_0003);
        check("t3_second_en", 32'(wb.rd_en), 1);
        check("t3_wb_count", wb_count, 3);
        check("t3_busy3_clr", 32'(rs1_busy), 0);
        check("t3_busy7_clr", 32'(rs2_busy), 0);
        check("t3_sb_err", 32'(sb_err), 0);

        // 4: result to x0
        wb.exu_valid = 1'b1; wb.exu_rd_addr = 5'd0; wb.exu_rd_data = 32'h0000_1234;
        tick();
        wb.exu_valid = 1'b0;
        rs1_addr = 5'd0;
        #1;
        check("t4_rd_en", 32'(wb.rd_en), 0);
        check("t4_wb_count", wb_count, 4);
        check("t4_sb_err", 32'(sb_err), 0);
        check("t4_rs1_fwd_x0", 32'(rs1_fwd), 0);
        check_all_idle("t4_busy_count");

        // 5: clear and set on the same register, same edge
        issue(5'd9);
        rs1_addr = 5'd9;
        #1;
        check("t5_busy9_pre", 32'(rs1_busy), 1);
        wb.lsu_valid = 1'b1; wb.lsu_rd_addr = 5'd9; wb.lsu_rd_data = 32'h0000_0099;
        issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd_addr = 5'd9;
        tick();
        wb.lsu_valid = 1'b0;
        issue_valid = 1'b0; issue_rd_en = 1'b0; issue_rd_addr = '0;
        #1;
        check("t5_busy9_kept", 32'(rs1_busy), 1);
        check("t5_rd_en", 32'(wb.rd_en), 1);
        check("t5_rd_addr", 32'(wb.rd_addr), 9);
        check("t5_rd_data", wb.rd_data, 32'h0000_0099);
        check("t5_wb_count", wb_count, 5);
        check("t5_sb_err", 32'(sb_err), 0);
        wb.lsu_valid = 1'b1; wb.lsu_rd_addr = 5'd9; wb.lsu_rd_data = 32'h0000_0199;
        tick();
        wb.lsu_valid = 1'b0;
        #1;
        check("t5_busy9_clr", 32'(rs1_busy), 0);
        check("t5_sb_err_after", 32'(sb_err), 0);
        check("t5_wb_count2", wb_count, 6);

        // 6: result for a non-busy register
        wb.exu_valid = 1'b1; wb.exu_rd_addr = 5'd12; wb.exu_rd_data = 32'h0000_0C0C;
        tick();
        wb.exu_valid = 1'b0;
        check("t6_sb_err_set", 32'(sb_err), 1);
        tick();
        tick();
        check("t6_sb_err_sticky", 32'(sb_err), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_sb_err_async_clr", 32'(sb_err), 0);
        check("t6_wb_count_clr", wb_count, 0);
        check("t6_rd_addr_clr", 32'(wb.rd_addr), 0);
        tick();
        reset = 1'b1;

        // Reset during a firing cycle drops the write
        issue(5'd4);
        wb.exu_valid = 1'b1; wb.exu_rd_addr = 5'd4; wb.exu_rd_data = 32'h0000_4444;
        #1;
        reset = 1'b0;
        tick();
        idle();
        check("rst_mid_rd_en", 32'(wb.rd_en), 0);
        check("rst_mid_wb_count", wb_count, 0);
        check("rst_mid_rd_data", wb.rd_data, 0);
        rs1_addr = 5'd4;
        #1;
        check("rst_mid_busy4", 32'(rs1_busy), 0);
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_rd_en_after", 32'(wb.rd_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
